// File: rtl/delay_cal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_cal_pkg
// Brief    : Shared state encoding, default widths and constants for the
//            delay-code calibrator.
// Revision : 1.0 - initial release
// ============================================================================
package delay_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_GATE   = 3'd2,
        ST_EVAL   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int c_def_n        = 16;
    localparam int c_def_log2_n   = 4;
    localparam int c_def_settle   = 256;
    localparam int c_def_gate     = 65536;
    localparam int c_def_cnt_w    = 20;

    localparam logic [c_def_cnt_w-1:0] c_err_ones = '1;

    // Timer must reach the longer of the two phase lengths.
    function automatic int timer_width(input int settle, input int gate);
        int longest;
        longest = (settle > gate) ? settle : gate;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_code_calibrator_osc_edge_counter.sv
`default_nettype none
// ============================================================================
// Module   : osc_edge_counter
// Brief    : Synchronises the divided ring output and counts its rising edges
//            into a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module osc_edge_counter
    import delay_cal_pkg::*;
#(
    parameter int CNT_W = c_def_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_div,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             w_rise;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= osc_div;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;

    // Hold at full scale so an over-fast ring reads as "too fast", never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && w_rise && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/delay_code_calibrator.sv
`default_nettype none
// ============================================================================
// Module   : delay_code_calibrator
// Brief    : Sweeps the delay-line code, measures ring frequency per code and
//            locks the code whose edge count is closest to the target.
// Revision : 1.0 - initial release
// ============================================================================
module delay_code_calibrator
    import delay_cal_pkg::*;
#(
    parameter int N             = c_def_n,
    parameter int LOG2_N        = c_def_log2_n,
    parameter int SETTLE_CYCLES = c_def_settle,
    parameter int GATE_CYCLES   = c_def_gate,
    parameter int CNT_W         = c_def_cnt_w
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [CNT_W-1:0]  target_count,
    input  logic              osc_div,
    output logic [LOG2_N-1:0] code,
    output logic              busy,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  meas_count,
    output logic [LOG2_N-1:0] best_code,
    output logic [CNT_W-1:0]  best_error,
    output logic              done
);

    localparam int                 c_tmr_w       = timer_width(SETTLE_CYCLES, GATE_CYCLES);
    localparam logic [c_tmr_w-1:0] c_settle_last = c_tmr_w'(SETTLE_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_gate_last   = c_tmr_w'(GATE_CYCLES - 1);
    localparam logic [LOG2_N-1:0]  c_last_code   = LOG2_N'(N - 1);
    localparam logic [CNT_W-1:0]   c_err_sat     = '1;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_tmr_w-1:0]  r_timer;
    logic [LOG2_N-1:0]   r_code;
    logic [CNT_W-1:0]    r_target;
    logic [LOG2_N-1:0]   r_best_code;
    logic [CNT_W-1:0]    r_best_error;
    logic                w_busy;
    logic                w_meas_valid;
    logic                w_done;
    logic                w_cnt_clear;
    logic                w_cnt_en;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W:0]      w_diff;
    logic [CNT_W-1:0]    w_err;

    osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .osc_div (osc_div),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_en),
        .count   (w_count)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_meas_valid = 1'b0;
        w_done       = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_busy      = 1'b1;
                w_cnt_clear = 1'b1;
                if (r_timer == c_settle_last) w_next_state = ST_GATE;
            end
            ST_GATE: begin
                w_busy   = 1'b1;
                w_cnt_en = 1'b1;
                if (r_timer == c_gate_last) w_next_state = ST_EVAL;
            end
            ST_EVAL: begin
                w_busy       = 1'b1;
                w_meas_valid = 1'b1;
                w_next_state = (r_code == c_last_code) ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Timer restarts on every phase change so each phase counts from zero.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_timer <= '0;
        end else if (r_state != w_next_state) begin
            r_timer <= '0;
        end else if ((r_state == ST_SETTLE) || (r_state == ST_GATE)) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_diff = (w_count >= r_target) ? ({1'b0, w_count} - {1'b0, r_target})
                                          : ({1'b0, r_target} - {1'b0, w_count});
    assign w_err  = w_diff[CNT_W] ? c_err_sat : w_diff[CNT_W-1:0];

    // Strict compare keeps the lower code on ties.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_code       <= '0;
            r_target     <= '0;
            r_best_code  <= '0;
            r_best_error <= c_err_sat;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_target     <= target_count;
                        r_code       <= '0;
                        r_best_code  <= '0;
                        r_best_error <= c_err_sat;
                    end
                end
                ST_EVAL: begin
                    if (w_err < r_best_error) begin
                        r_best_code  <= r_code;
                        r_best_error <= w_err;
                    end
                    if (r_code != c_last_code) r_code <= r_code + 1'b1;
                end
                ST_DONE: r_code <= r_best_code;
                default: ;
            endcase
        end
    end

    assign code       = r_code;
    assign busy       = w_busy;
    assign meas_valid = w_meas_valid;
    assign meas_count = w_count;
    assign best_code  = r_best_code;
    assign best_error = r_best_error;
    assign done       = w_done;

endmodule
`default_nettype wire

// File: tb/tb_delay_code_calibrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_code_calibrator
// Brief    : Self-checking bench: ring model driven by the live code, argmin
//            reference for the code selection, saturation on a narrow copy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_code_calibrator;

    localparam int N      = 4;
    localparam int LOG2_N = 2;
    localparam int S      = 4;
    localparam int G      = 40;
    localparam int CNT_W  = 20;
    localparam int SAT_W  = 3;
    localparam int PER    = S + G + 1;
    localparam int ALL1   = (1 << CNT_W) - 1;
    localparam int SALL1  = (1 << SAT_W) - 1;

    logic              CLOCK_50 = 1'b0;
    logic              RESET_N  = 1'b0;
    logic              start    = 1'b0;
    logic              osc_div  = 1'b0;
    logic              osc_fast = 1'b0;
    logic [CNT_W-1:0]  target_count = '0;
    logic [SAT_W-1:0]  target_sat   = '0;

    logic [LOG2_N-1:0] code, best_code, s_code, s_best_code;
    logic              busy, meas_valid, done, s_busy, s_meas_valid, s_done;
    logic [CNT_W-1:0]  meas_count, best_error;
    logic [SAT_W-1:0]  s_meas_count, s_best_error;

    int tests = 0;
    int fails = 0;
    int h_tab[N];
    int osc_cnt  = 0;
    int fast_cnt = 0;

    delay_code_calibrator #(
        .N(N), .LOG2_N(LOG2_N), .SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start),
        .target_count(target_count), .osc_div(osc_div), .code(code),
        .busy(busy), .meas_valid(meas_valid), .meas_count(meas_count),
        .best_code(best_code), .best_error(best_error), .done(done)
    );

    delay_code_calibrator #(
        .N(N), .LOG2_N(LOG2_N), .SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(SAT_W)
    ) dut_sat (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start),
        .target_count(target_sat), .osc_div(osc_fast), .code(s_code),
        .busy(s_busy), .meas_valid(s_meas_valid), .meas_count(s_meas_count),
        .best_code(s_best_code), .best_error(s_best_error), .done(s_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Ring model: half-period h_tab[code] reference cycles; fast ring half-period 2.
    always @(posedge CLOCK_50) begin
        #2;
        osc_cnt++;
        if (osc_cnt >= h_tab[code]) begin
            osc_cnt = 0;
            osc_div = ~osc_div;
        end
        fast_cnt++;
        if (fast_cnt >= 2) begin
            fast_cnt = 0;
            osc_fast = ~osc_fast;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_code"}, code, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mvalid"}, meas_valid, 0);
        chk({tag, "_mcount"}, meas_count, 0);
        chk({tag, "_bcode"}, best_code, 0);
        chk({tag, "_berr"}, best_error, ALL1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sat_berr"}, s_best_error, SALL1);
    endtask

    // One full sweep with per-cycle observation and a reference argmin at the end.
    task automatic sweep(input int tgt, input int tgt_s, input bit poke, input bit exact);
        int cnt[N];
        int vcyc[N];
        int vcode[N];
        int nv = 0;
        int busy_bad = 0;
        int done_hits = 0;
        int done_cyc = -1;
        int bc_d = -1, be_d = -1, sbc_d = -1, sbe_d = -1;
        int exp_code, exp_err, e, d, h, ok, sat_exp, s_exp_err, late_busy;
        sat_exp = (G / 4 > SALL1) ? SALL1 : G / 4;
        target_count = CNT_W'(tgt);
        target_sat   = SAT_W'(tgt_s);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_code", code, 0);
        for (int cyc = 1; cyc <= N * PER + 4; cyc++) begin
            if (poke) start = (cyc == 2 * PER + S + 15);
            if (meas_valid === 1'b1) begin
                if (nv < N) begin
                    cnt[nv]   = int'(meas_count);
                    vcyc[nv]  = cyc;
                    vcode[nv] = int'(code);
                end
                nv++;
            end
            if (s_meas_valid === 1'b1) chk("sat_count", s_meas_count, sat_exp);
            if (done === 1'b1) begin
                done_hits++;
                done_cyc = cyc;
                bc_d  = int'(best_code);
                be_d  = int'(best_error);
                sbc_d = int'(s_best_code);
                sbe_d = int'(s_best_error);
                chk("busy_during_done", busy, 0);
            end else if (cyc <= N * PER && busy !== 1'b1) begin
                busy_bad++;
            end
            step();
        end
        start = 1'b0;
        chk("busy_hold", busy_bad, 0);
        chk("meas_pulses", nv, N);
        chk("done_once", done_hits, 1);
        chk("done_cycle", done_cyc, 1 + N * PER);

        exp_err = ALL1;
        exp_code = 0;
        s_exp_err = SALL1;
        for (int k = 0; k < N; k++) begin
            h = h_tab[k];
            chk("meas_cycle", vcyc[k], PER * (k + 1));
            chk("eval_code", vcode[k], k);
            if (exact) begin
                chk("meas_exact", cnt[k], G / (2 * h));
            end else begin
                d  = cnt[k] * 2 * h - G;
                ok = ((d >= -2 * h) && (d <= 2 * h)) ? 1 : 0;
                chk("meas_tol", ok, 1);
            end
            e = (cnt[k] > tgt) ? cnt[k] - tgt : tgt - cnt[k];
            if (e < exp_err) begin
                exp_err  = e;
                exp_code = k;
            end
            e = (sat_exp > tgt_s) ? sat_exp - tgt_s : tgt_s - sat_exp;
            if (e < s_exp_err) s_exp_err = e;
        end
        chk("best_code", bc_d, exp_code);
        chk("best_error", be_d, exp_err);
        chk("sat_best_code", sbc_d, 0);
        chk("sat_best_error", sbe_d, s_exp_err);
        chk("locked_code", code, exp_code);
        chk("idle_busy", busy, 0);

        if (poke) begin
            late_busy = 0;
            for (int i = 0; i < 60; i++) begin
                if (busy !== 1'b0 || done !== 1'b0) late_busy++;
                step();
            end
            chk("no_resweep", late_busy, 0);
            chk("still_locked", code, exp_code);
        end
    endtask

    initial begin
        int stray;
        h_tab = '{2, 3, 4, 5};
        RESET_N = 1'b0;
        repeat (3) step();
        chk_reset_values("rst");
        RESET_N = 1'b1;
        repeat (5) step();

        // Monotonic sweep around target 6, then random targets.
        sweep(6, 5, 1'b0, 1'b0);
        repeat (5) step();
        for (int i = 0; i < 3; i++) begin
            sweep(int'($urandom_range(0, 14)), int'($urandom_range(0, 7)), 1'b0, 1'b0);
            repeat (int'($urandom_range(2, 9))) step();
        end

        // Start request during GATE of code 2; target 0 on the narrow copy.
        sweep(int'($urandom_range(0, 14)), 0, 1'b1, 1'b0);
        repeat (5) step();

        // Reset during SETTLE of code 1.
        target_count = CNT_W'(6);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (46) step();
        chk("pre_reset_code", code, 1);
        chk("pre_reset_busy", busy, 1);
        RESET_N = 1'b0;
        #1;
        chk_reset_values("async_rst");
        step();
        chk_reset_values("rst_next");
        RESET_N = 1'b1;
        stray = 0;
        for (int i = 0; i < 2 * N * PER; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) stray++;
            step();
        end
        chk("no_done_after_abort", stray, 0);

        sweep(6, int'($urandom_range(0, 7)), 1'b0, 1'b0);
        repeat (5) step();

        // Every code rings identically: all errors tie, lowest code must win.
        h_tab = '{4, 4, 4, 4};
        repeat (20) step();
        sweep(int'($urandom_range(0, 14)), int'($urandom_range(0, 7)), 1'b0, 1'b1);
        chk("tie_lowest", code, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
